dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter_starve_guard.sv | 38 +++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared word type and arbiter state codes; also used by the processor top
// when the arbiter sits in front of datamem.
package dmem_arbiter_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic word_t pick_word(input logic host, input word_t h_w, input word_t p_w);
    return host ? h_w : p_w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (pipeline + host) and the single-port memory command bus.
// slave = arbiter side, master = requesters and memory.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic  p_req;
  logic  p_we;
  word_t p_addr;
  word_t p_wdata;
  logic  p_ack;
  word_t p_rdata;
  logic  p_stall;

  logic  h_req;
  logic  h_we;
  word_t h_addr;
  word_t h_wdata;
  logic  h_ack;
  word_t h_rdata;

  logic  mem_en;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  busy;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_ack, p_rdata, p_stall,
    input  h_req, h_we, h_addr, h_wdata,
    output h_ack, h_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_ack, p_rdata, p_stall,
    output h_req, h_we, h_addr, h_wdata,
    input  h_ack, h_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter_starve_guard.sv
// Grant select with a saturating count of pipeline grants taken while the host
// waits; host_wins is combinational, the count updates on the grant edge.
module dmem_arbiter_starve_guard #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic p_req_i,
  input  logic h_req_i,
  input  logic grant_i,
  output logic host_wins_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign host_wins_o = h_req_i && (!p_req_i || (cnt_q == CNT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i && host_wins_o) begin
      cnt_d = '0;
    end else if (grant_i && h_req_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (idle_i && !h_req_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// One-at-a-time arbiter for the shared data memory: pipeline first, host guarded
// against starvation. Request to ack is MEM_LAT+2 cycles; losers are held via stall.
module dmem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  import dmem_arbiter_pkg::*;

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             host_q;
  logic             we_q;
  word_t            addr_q;
  word_t            wdata_q;
  word_t            p_rdata_q;
  word_t            h_rdata_q;

  logic in_idle;
  logic grant;
  logic host_wins;
  logic lat_done;
  logic capture;
  logic issue;
  logic p_ack;

  assign in_idle  = (state_q == IDLE);
  assign grant    = in_idle && (bus.p_req || bus.h_req);
  assign lat_done = (lat_q == LAT_W'(MEM_LAT - 1));
  assign capture  = (state_q == WAIT) && lat_done;
  assign issue    = (state_q == ISSUE);

  dmem_arbiter_starve_guard #(
    .STARVE_MAX (STARVE_MAX)
  ) u_guard (
    .clk         (clk),
    .reset       (reset),
    .idle_i      (in_idle),
    .p_req_i     (bus.p_req),
    .h_req_i     (bus.h_req),
    .grant_i     (grant),
    .host_wins_o (host_wins)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: begin
        if (lat_done) state_d = RESP;
        else          lat_d   = lat_q + LAT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      host_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      // Requester inputs are only looked at on the grant edge.
      if (grant) begin
        host_q  <= host_wins;
        we_q    <= host_wins ? bus.h_we : bus.p_we;
        addr_q  <= pick_word(host_wins, bus.h_addr, bus.p_addr);
        wdata_q <= pick_word(host_wins, bus.h_wdata, bus.p_wdata);
      end
      if (capture && !we_q) begin
        if (host_q) h_rdata_q <= bus.mem_rdata;
        else        p_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign p_ack         = (state_q == RESP) && !host_q;
  assign bus.p_ack     = p_ack;
  assign bus.h_ack     = (state_q == RESP) && host_q;
  assign bus.p_stall   = bus.p_req && !p_ack;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = !in_idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: two arbiters (MEM_LAT 1 and 3) each in front of a small memory model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();

  dmem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic word_t rom(input word_t a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0030: return 16'h5A5A;
      16'h0040: return 16'hCAFE;
      default:  return a ^ 16'h5555;
    endcase
  endfunction

  word_t garb;
  assign garb = 16'hA5A5 ^ cyc;

  // Memory for the MEM_LAT=1 arbiter: writable, one-cycle read.
  word_t mem0 [0:255];
  bit    wr0  [0:255];
  word_t d0_q;
  bit    v0_q;
  always @(posedge clk) begin
    v0_q <= bus0.mem_en && !bus0.mem_we;
    if (bus0.mem_en && !bus0.mem_we)
      d0_q <= wr0[bus0.mem_addr[7:0]] ? mem0[bus0.mem_addr[7:0]] : rom(bus0.mem_addr);
    if (bus0.mem_en && bus0.mem_we) begin
      mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
      wr0[bus0.mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign bus0.mem_rdata = v0_q ? d0_q : garb;

  // Memory for the MEM_LAT=3 arbiter: read-only, garbage outside the valid slot.
  word_t d1_q [0:2];
  bit    v1_q [0:2];
  always @(posedge clk) begin
    v1_q[0] <= bus1.mem_en && !bus1.mem_we;
    d1_q[0] <= rom(bus1.mem_addr);
    for (int k = 1; k < 3; k++) begin
      v1_q[k] <= v1_q[k-1];
      d1_q[k] <= d1_q[k-1];
    end
  end
  assign bus1.mem_rdata = v1_q[2] ? d1_q[2] : garb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bus0.mem_en, bus0.mem_we, bus0.p_ack, bus0.h_ack, bus0.busy, bus0.p_stall} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl0 got %b want 000000", {bus0.mem_en, bus0.mem_we, bus0.p_ack, bus0.h_ack, bus0.busy, bus0.p_stall});
    end
    n_vec++;
    if ({bus0.mem_addr, bus0.mem_wdata, bus0.p_rdata, bus0.h_rdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_words0 got %h want 0", {bus0.mem_addr, bus0.mem_wdata, bus0.p_rdata, bus0.h_rdata});
    end
    n_vec++;
    if ({bus1.mem_en, bus1.busy, bus1.p_ack, bus1.h_ack, bus1.p_rdata, bus1.h_rdata} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_lat3 got %h want 0", {bus1.mem_en, bus1.busy, bus1.p_ack, bus1.h_ack, bus1.p_rdata, bus1.h_rdata});
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_pipe_read();
    tick();
    bus0.p_req = 1'b1; bus0.p_we = 1'b0; bus0.p_addr = 16'h0010; bus0.p_wdata = 16'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus0.mem_en !== (k == 1)) begin
        n_err++; $display("FAIL pipe_read mem_en k=%0d got %b want %b", k, bus0.mem_en, k == 1);
      end
      n_vec++;
      if (bus0.p_stall !== (k < 3)) begin
        n_err++; $display("FAIL pipe_read p_stall k=%0d got %b want %b", k, bus0.p_stall, k < 3);
      end
      n_vec++;
      if (bus0.p_ack !== (k == 3) || bus0.h_ack !== 1'b0) begin
        n_err++; $display("FAIL pipe_read ack k=%0d got p=%b h=%b want p=%b h=0", k, bus0.p_ack, bus0.h_ack, k == 3);
      end
      n_vec++;
      if (bus0.busy !== (k >= 1 && k <= 3)) begin
        n_err++; $display("FAIL pipe_read busy k=%0d got %b want %b", k, bus0.busy, k >= 1 && k <= 3);
      end
      if (k == 1) begin
        n_vec++;
        if (bus0.mem_addr !== 16'h0010 || bus0.mem_we !== 1'b0) begin
          n_err++; $display("FAIL pipe_read cmd got addr=%h we=%b want addr=0010 we=0", bus0.mem_addr, bus0.mem_we);
        end
      end
      if (k == 3) begin
        n_vec++;
        if (bus0.p_rdata !== 16'hBEEF) begin
          n_err++; $display("FAIL pipe_read p_rdata got %h want beef", bus0.p_rdata);
        end
      end
      tick();
      if (k == 3) bus0.p_req = 1'b0;
    end
  endtask

  task automatic test_host_write();
    int en_cnt;
    en_cnt = 0;
    tick();
    bus0.h_req = 1'b1; bus0.h_we = 1'b1; bus0.h_addr = 16'h0020; bus0.h_wdata = 16'h1234;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus0.mem_en) begin
        en_cnt++;
        n_vec++;
        if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 16'h0020 || bus0.mem_wdata !== 16'h1234) begin
          n_err++; $display("FAIL host_write cmd got we=%b addr=%h data=%h want 1 0020 1234", bus0.mem_we, bus0.mem_addr, bus0.mem_wdata);
        end
      end else begin
        n_vec++;
        if (bus0.mem_we !== 1'b0) begin
          n_err++; $display("FAIL host_write idle_we k=%0d got %b want 0", k, bus0.mem_we);
        end
      end
      n_vec++;
      if (bus0.h_ack !== (k == 3) || bus0.p_ack !== 1'b0) begin
        n_err++; $display("FAIL host_write ack k=%0d got h=%b p=%b want h=%b p=0", k, bus0.h_ack, bus0.p_ack, k == 3);
      end
      tick();
      if (k == 3) bus0.h_req = 1'b0;
    end
    bus0.h_we = 1'b0;
    n_vec++;
    if (en_cnt !== 1) begin
      n_err++; $display("FAIL host_write en_cycles got %0d want 1", en_cnt);
    end
    n_vec++;
    if (bus0.p_rdata !== 16'hBEEF || bus0.h_rdata !== 16'h0000) begin
      n_err++; $display("FAIL host_write rdata got p=%h h=%h want beef 0000", bus0.p_rdata, bus0.h_rdata);
    end
    n_vec++;
    if (mem0[8'h20] !== 16'h1234) begin
      n_err++; $display("FAIL host_write mem got %h want 1234", mem0[8'h20]);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] order;
    int n_ack, overlap, first_cyc, last_cyc;
    order = '0; n_ack = 0; overlap = 0; first_cyc = 0; last_cyc = 0;
    tick();
    bus0.p_req = 1'b1; bus0.p_we = 1'b0; bus0.p_addr = 16'h0010;
    bus0.h_req = 1'b1; bus0.h_we = 1'b0; bus0.h_addr = 16'h0030;
    for (int i = 0; i < 80 && n_ack < 10; i++) begin
      @(negedge clk);
      if (bus0.p_ack && bus0.h_ack) overlap++;
      if (bus0.p_ack || bus0.h_ack) begin
        order[n_ack] = bus0.h_ack;
        if (n_ack == 0) first_cyc = int'(cyc);
        last_cyc = int'(cyc);
        n_vec++;
        if (bus0.h_ack && bus0.h_rdata !== 16'h5A5A) begin
          n_err++; $display("FAIL starve h_rdata n=%0d got %h want 5a5a", n_ack, bus0.h_rdata);
        end else if (!bus0.h_ack && bus0.p_rdata !== 16'hBEEF) begin
          n_err++; $display("FAIL starve p_rdata n=%0d got %h want beef", n_ack, bus0.p_rdata);
        end
        n_ack++;
      end
    end
    tick();
    bus0.p_req = 1'b0; bus0.h_req = 1'b0;
    n_vec++;
    if (n_ack !== 10) begin
      n_err++; $display("FAIL starve ack_count got %0d want 10", n_ack);
    end
    n_vec++;
    if (order !== 10'b1000010000) begin
      n_err++; $display("FAIL starve order got %b want 1000010000 (bit i = grant i is host)", order);
    end
    n_vec++;
    if (overlap !== 0) begin
      n_err++; $display("FAIL starve overlap got %0d want 0", overlap);
    end
    n_vec++;
    if (last_cyc - first_cyc !== 36) begin
      n_err++; $display("FAIL starve throughput got %0d cycles want 36", last_cyc - first_cyc);
    end
  endtask

  task automatic test_lat3();
    tick();
    bus1.p_req = 1'b1; bus1.p_we = 1'b0; bus1.p_addr = 16'h0040; bus1.p_wdata = 16'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus1.p_ack !== (k == 5) || bus1.mem_en !== (k == 1)) begin
        n_err++; $display("FAIL lat3 ctrl k=%0d got ack=%b en=%b want ack=%b en=%b", k, bus1.p_ack, bus1.mem_en, k == 5, k == 1);
      end
      n_vec++;
      if (k < 5 && bus1.p_rdata !== 16'h0000) begin
        n_err++; $display("FAIL lat3 early_rdata k=%0d got %h want 0000", k, bus1.p_rdata);
      end else if (k >= 5 && bus1.p_rdata !== 16'hCAFE) begin
        n_err++; $display("FAIL lat3 p_rdata k=%0d got %h want cafe", k, bus1.p_rdata);
      end
      tick();
      if (k == 5) bus1.p_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int quiet_bad;
    logic [4:0] order;
    n = 0; quiet_bad = 0; order = '0;
    tick();
    bus0.p_req = 1'b1; bus0.p_addr = 16'h0010; bus0.h_req = 1'b1; bus0.h_addr = 16'h0030;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (bus0.p_ack) n++;
    end
    n_vec++;
    if (n !== 2) begin
      n_err++; $display("FAIL reset_mid pre_acks got %0d want 2", n);
    end
    tick(); tick(); tick();
    #2;
    n_vec++;
    if (bus0.busy !== 1'b1) begin
      n_err++; $display("FAIL reset_mid busy_before got %b want 1", bus0.busy);
    end
    reset = 1'b0;
    bus0.p_req = 1'b0; bus0.h_req = 1'b0;
    #1;
    n_vec++;
    if ({bus0.busy, bus0.mem_en, bus0.p_ack, bus0.h_ack} !== 4'b0) begin
      n_err++; $display("FAIL reset_mid async got %b want 0000", {bus0.busy, bus0.mem_en, bus0.p_ack, bus0.h_ack});
    end
    tick();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.busy || bus0.p_ack || bus0.h_ack || bus0.mem_en) quiet_bad++;
    end
    n_vec++;
    if (quiet_bad !== 0) begin
      n_err++; $display("FAIL reset_mid quiet got %0d active cycles want 0", quiet_bad);
    end
    n_vec++;
    if (bus0.p_rdata !== 16'h0000) begin
      n_err++; $display("FAIL reset_mid p_rdata got %h want 0000", bus0.p_rdata);
    end
    tick();
    bus0.p_req = 1'b1; bus0.h_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      if (bus0.p_ack || bus0.h_ack) begin
        order[n] = bus0.h_ack;
        n++;
      end
    end
    tick();
    bus0.p_req = 1'b0; bus0.h_req = 1'b0;
    n_vec++;
    if (n !== 5 || order !== 5'b10000) begin
      n_err++; $display("FAIL reset_mid restart got n=%0d order=%b want 5 10000", n, order);
    end
  endtask

  initial begin
    bus0.p_req = 1'b0; bus0.p_we = 1'b0; bus0.p_addr = '0; bus0.p_wdata = '0;
    bus0.h_req = 1'b0; bus0.h_we = 1'b0; bus0.h_addr = '0; bus0.h_wdata = '0;
    bus1.p_req = 1'b0; bus1.p_we = 1'b0; bus1.p_addr = '0; bus1.p_wdata = '0;
    bus1.h_req = 1'b0; bus1.h_we = 1'b0; bus1.h_addr = '0; bus1.h_wdata = '0;
    test_reset();
    test_pipe_read();
    test_host_write();
    test_starvation();
    test_lat3();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1);
  end

endmodule
